display_scan_driver: RTL and testbench

//  Write-port receiver for the 8-digit display buffer protocol (W/WADD/DIN) driven by the display controller.

---
 rtl/display_pkg.sv | 28 ++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/display_scan_driver.sv | 112 +++++++++++
 tb/tb_display_scan_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the 8-digit multiplexed 7-segment display driver.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DIN_W      = 6;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned EN_BIT     = 5;
  localparam int unsigned HEX_MSB    = 4;
  localparam int unsigned HEX_LSB    = 1;
  localparam int unsigned DPN_BIT    = 0;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  // One digit-memory entry, laid out to match the DIN write payload
  typedef struct packed {
    logic       en;
    logic [3:0] hex;
    logic       dp_n;
  } digit_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    unique case (hex)
      4'h0: seg_c = 7'b1000000;
      4'h1: seg_c = 7'b1111001;
      4'h2: seg_c = 7'b0100100;
      4'h3: seg_c = 7'b0110000;
      4'h4: seg_c = 7'b0011001;
      4'h5: seg_c = 7'b0010010;
      4'h6: seg_c = 7'b0000010;
      4'h7: seg_c = 7'b1111000;
      4'h8: seg_c = 7'b0000000;
      4'h9: seg_c = 7'b0010000;
      4'hA: seg_c = 7'b0001000;
      4'hB: seg_c = 7'b0000011;
      4'hC: seg_c = 7'b1000110;
      4'hD: seg_c = 7'b0100001;
      4'hE: seg_c = 7'b0000110;
      4'hF: seg_c = 7'b0001110;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// Digit buffer write port plus time-multiplexed scan of an 8-digit common-anode display,
// with an optional all-dark gap between digits and a frame-complete pulse.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  W,
  input  logic [IDX_W-1:0]      WADD,
  input  logic [DIN_W-1:0]      DIN,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  digit_t mem [NUM_DIGITS];

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wrap_c;
  logic                  lit_c;
  digit_t                cur_c;
  logic [SEG_W-1:0]      dec_seg_c;
  logic [NUM_DIGITS-1:0] an_d;
  logic [SEG_W-1:0]      seg_d;
  logic                  dp_d;

  // Digit memory: one write per cycle, no handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) mem[i] <= '0;
    end else if (W) begin
      mem[WADD] <= digit_t'(DIN);
    end
  end

  assign cur_c = mem[idx_q];

  hex_to_seg7 u_dec (
    .hex   (cur_c.hex),
    .seg_c (dec_seg_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SHOW;
      idx_q      <= '0;
      cnt_q      <= '0;
      an         <= ANODE_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= wrap_c;
    end
  end

  // Scan sequencing; outputs are derived from the current registered state only,
  // so at most one anode can ever be driven low.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    wrap_c  = 1'b0;

    unique case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) begin
            idx_d  = idx_q + IDX_W'(1);
            wrap_c = (idx_q == LAST_IDX);
          end else begin
            state_d = BLANK;
          end
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          idx_d   = idx_q + IDX_W'(1);
          wrap_c  = (idx_q == LAST_IDX);
        end
      end
      default: state_d = SHOW;
    endcase

    lit_c = (state_q == SHOW) && cur_c.en;
    an_d  = lit_c ? ~(NUM_DIGITS'(1) << idx_q) : ANODE_OFF;
    seg_d = lit_c ? dec_seg_c : SEG_BLANK;
    dp_d  = lit_c ? cur_c.dp_n : 1'b1;
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: frame-position arithmetic model checked every cycle,
// plus directed literal checks; a second instance runs with no blanking gap.
module tb_display_scan_driver;

  localparam int R  = 4;
  localparam int B  = 2;
  localparam int B0 = 0;

  logic       clk;
  logic       rst;
  logic       W;
  logic [2:0] WADD;
  logic [5:0] DIN;

  logic [7:0] an, an0;
  logic [6:0] seg, seg0;
  logic       dp, dp0;
  logic       frame_done, frame_done0;

  int total = 0;
  int bad   = 0;

  display_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .W(W), .WADD(WADD), .DIN(DIN),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  display_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B0)) dut0 (
    .clk(clk), .rst(rst), .W(W), .WADD(WADD), .DIN(DIN),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(frame_done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0] mmem [8];
  int         n;

  function automatic int digit_of(input int cyc, input int r, input int b);
    return (cyc % (8 * (r + b))) / (r + b);
  endfunction

  function automatic bit show_of(input int cyc, input int r, input int b);
    return ((cyc % (8 * (r + b))) % (r + b)) < r;
  endfunction

  task automatic expect_for(input int cyc, input int r, input int b,
                            output logic [7:0] e_an, output logic [6:0] e_seg,
                            output logic e_dp, output logic e_fd);
    int d;
    logic [5:0] v;
    bit lit;
    d   = digit_of(cyc, r, b);
    v   = mmem[d];
    lit = show_of(cyc, r, b) && v[5];
    e_an  = lit ? ~(8'b1 << d) : 8'hFF;
    e_seg = lit ? seg_tab[v[4:1]] : 7'h7F;
    e_dp  = lit ? v[0] : 1'b1;
    e_fd  = ((cyc + 1) % (8 * (r + b))) == 0;
  endtask

  logic [7:0] e_an, e_an0;
  logic [6:0] e_seg, e_seg0;
  logic       e_dp, e_dp0, e_fd, e_fd0;

  // Per-cycle compare against the model
  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      for (int i = 0; i < 8; i++) mmem[i] = 6'd0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      e_an0 = 8'hFF; e_seg0 = 7'h7F; e_dp0 = 1'b1; e_fd0 = 1'b0;
    end else begin
      expect_for(n, R, B,  e_an,  e_seg,  e_dp,  e_fd);
      expect_for(n, R, B0, e_an0, e_seg0, e_dp0, e_fd0);
      n++;
      if (W) mmem[WADD] = DIN;
    end
    #2;
    chk("an", {24'd0, an}, {24'd0, e_an});
    chk("seg", {25'd0, seg}, {25'd0, e_seg});
    chk("dp", {31'd0, dp}, {31'd0, e_dp});
    chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    chk("an_b0", {24'd0, an0}, {24'd0, e_an0});
    chk("seg_b0", {25'd0, seg0}, {25'd0, e_seg0});
    chk("dp_b0", {31'd0, dp0}, {31'd0, e_dp0});
    chk("frame_done_b0", {31'd0, frame_done0}, {31'd0, e_fd0});
    chk("one_anode", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    chk("one_anode_b0", {31'd0, ($countones(~an0) <= 1)}, 32'd1);
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] s_an  [48];
  logic [6:0] s_seg [48];
  logic       s_fd  [48];
  logic [7:0] s_an0 [48];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] d);
    @(negedge clk);
    W = 1'b1; WADD = a; DIN = d;
    @(negedge clk);
    W = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    bit found = 0;
    for (int i = 0; i < 120 && !found; i++) begin
      tick();
      if (frame_done) found = 1;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  task automatic capture48();
    for (int i = 0; i < 48; i++) begin
      tick();
      s_an[i] = an; s_seg[i] = seg; s_fd[i] = frame_done; s_an0[i] = an0;
    end
  endtask

  function automatic int count_an(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 48; i++) if (s_an[i] == v) c++;
    return c;
  endfunction

  function automatic int count_fd();
    int c = 0;
    for (int i = 0; i < 48; i++) if (s_fd[i]) c++;
    return c;
  endfunction

  initial begin
    rst = 1'b1; W = 1'b0; WADD = 3'd0; DIN = 6'd0;
    repeat (3) @(negedge clk);
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    rst = 1'b0;

    // Memory cleared: whole frame dark
    capture48();
    chk("dark_after_reset", count_an(8'hFF), 32'd48);

    // Controller-style fill 7..0, back to back
    for (int k = 7; k >= 0; k--) begin
      @(negedge clk);
      W = 1'b1; WADD = 3'(k); DIN = {1'b1, 4'(k), 1'b1};
    end
    @(negedge clk);
    W = 1'b0;
    wait_frame("wait_frame_t2");
    capture48();
    chk("t2_an0",  {24'd0, s_an[0]},  32'hFE);
    chk("t2_seg0", {25'd0, s_seg[0]}, 32'h40);
    chk("t2_an3",  {24'd0, s_an[3]},  32'hFE);
    chk("t2_gap",  {24'd0, s_an[4]},  32'hFF);
    chk("t2_gap2", {24'd0, s_an[5]},  32'hFF);
    chk("t2_an6",  {24'd0, s_an[6]},  32'hFD);
    chk("t2_seg6", {25'd0, s_seg[6]}, 32'h79);
    chk("t2_an42", {24'd0, s_an[42]}, 32'h7F);
    chk("t2_seg42", {25'd0, s_seg[42]}, 32'h78);
    chk("t2_fd_count", count_fd(), 32'd1);
    chk("t2_fd_last", {31'd0, s_fd[47]}, 32'd1);
    chk("t2_dark_cycles", count_an(8'hFF), 32'd16);
    begin
      int ff0 = 0;
      for (int i = 0; i < 48; i++) if (s_an0[i] == 8'hFF) ff0++;
      chk("b0_no_gaps", ff0, 32'd0);
    end

    // No-blank instance: frame period 32
    begin
      int gap = 0;
      bit seen = 0, done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
        tick();
        if (seen) gap++;
        if (frame_done0) begin
          if (seen) done = 1;
          seen = 1;
        end
      end
      chk("b0_period_found", {31'd0, done}, 32'd1);
      chk("b0_period", gap, 32'd32);
    end

    // Digit 3 = F with decimal point lit
    wr(3'd3, 6'b1_1111_0);
    begin
      bit found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
        tick();
        if (an == 8'hF7) found = 1;
      end
      chk("t3_found", {31'd0, found}, 32'd1);
      chk("t3_seg", {25'd0, seg}, 32'h0E);
      chk("t3_dp", {31'd0, dp}, 32'd0);
    end

    // Digit 5 disabled: slot stays dark, period unchanged
    wr(3'd5, 6'b0_1000_1);
    wait_frame("wait_frame_t4");
    capture48();
    chk("t4_no_d5", count_an(8'hDF), 32'd0);
    chk("t4_d3_lit", count_an(8'hF7), 32'd4);
    chk("t4_fd_count", count_fd(), 32'd1);
    chk("t4_fd_last", {31'd0, s_fd[47]}, 32'd1);

    // Write into the lit digit 0 mid-SHOW
    begin
      bit found = 0;
      logic [7:0] prev = 8'h00;
      for (int i = 0; i < 80 && !found; i++) begin
        tick();
        if (an == 8'hFE && prev == 8'hFF) found = 1;
        prev = an;
      end
      chk("t5_found", {31'd0, found}, 32'd1);
      @(negedge clk);
      W = 1'b1; WADD = 3'd0; DIN = 6'b1_1000_1;
      tick();
      W = 1'b0;
      chk("t5_an_a", {24'd0, an}, 32'hFE);
      chk("t5_seg_old", {25'd0, seg}, 32'h40);
      tick();
      chk("t5_an_b", {24'd0, an}, 32'hFE);
      chk("t5_seg_new", {25'd0, seg}, 32'h00);
      tick();
      chk("t5_an_c", {24'd0, an}, 32'hFE);
      chk("t5_seg_hold", {25'd0, seg}, 32'h00);
    end

    // Asynchronous reset mid-run
    repeat (5) tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_an", {24'd0, an}, 32'hFF);
    chk("async_seg", {25'd0, seg}, 32'h7F);
    chk("async_dp", {31'd0, dp}, 32'd1);
    chk("async_fd", {31'd0, frame_done}, 32'd0);
    chk("async_an_b0", {24'd0, an0}, 32'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture48();
    chk("dark_after_midreset", count_an(8'hFF), 32'd48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
